// File: rtl/tdes_pkg.sv
// tdes_pkg
//   Shared definitions for the triple-DES input stager: register address
//   codes decoded from the low nibble of HADDR, the issue FSM state type and
//   default widths/depths.
package tdes_pkg;

    localparam int DATA_W_DEFAULT     = 64;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    localparam logic [3:0] ADDR_MODE = 4'h0;
    localparam logic [3:0] ADDR_KEY1 = 4'h1;
    localparam logic [3:0] ADDR_KEY2 = 4'h2;
    localparam logic [3:0] ADDR_KEY3 = 4'h3;
    localparam logic [3:0] ADDR_DATA = 4'h4;
    localparam logic [3:0] ADDR_CLR  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } stager_state_t;

endpackage

// File: rtl/tdes_sync_fifo.sv
// tdes_sync_fifo
//   Small synchronous FIFO holding data chunks waiting for the DES core.
//   The head entry is always visible on 'head'; fullness is tracked with an
//   explicit occupancy counter, so pointers simply wrap modulo DEPTH.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous reset, active-high
//   push   in   write 'data' (ignored when full)
//   pop    in   discard head entry (ignored when empty)
//   flush  in   empty the FIFO; overrides push and pop
//   data   in   WIDTH  entry to push
//   head   out  WIDTH  oldest entry
//   count  out  number of entries held
//   full   out  count == DEPTH
//   empty  out  count == 0
//
// DEPTH must be a power of two, at least 2.
module tdes_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full is judged on the current count, so a same-edge pop never makes room.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tdes_input_stager.sv
// tdes_input_stager
//   Stages register writes from the AHB-Lite slave controller for the
//   triple-DES core: holds mode and the three keys, queues data chunks and
//   hands them to the core one at a time with a start/done handshake.
//
// Ports
//   HCLK          in   clock, rising edge
//   HRESET        in   asynchronous reset, active-high
//   wr_en         in   one-cycle write strobe
//   wr_addr       in   4  register code (0 mode, 1-3 keys, 4 data, F clear)
//   wr_data       in   DATA_W write data
//   core_done     in   core finished the current chunk
//   core_start    out  one-cycle start pulse
//   core_data     out  DATA_W chunk for the core, held until core_done
//   key_one/two/three out DATA_W held keys
//   enc_dec       out  1 = encrypt, 0 = decrypt
//   fifo_count    out  chunks buffered
//   fifo_full/fifo_empty out FIFO status
//   keys_valid    out  all three keys written since reset
//   overflow_err  out  sticky: data write while FIFO full
//   key_err       out  sticky: mode/key write while locked
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO head when keys are valid
// ISSUE | core_start asserted for this single cycle
// BUSY  | chunk in flight, core_data held, waiting for core_done
module tdes_input_stager
    import tdes_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEFAULT,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              core_done,
    output logic              core_start,
    output logic [DATA_W-1:0] core_data,
    output logic [DATA_W-1:0] key_one,
    output logic [DATA_W-1:0] key_two,
    output logic [DATA_W-1:0] key_three,
    output logic              enc_dec,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              keys_valid,
    output logic              overflow_err,
    output logic              key_err
);

    stager_state_t     state_q;
    stager_state_t     state_d;
    logic [2:0]        key_mask;
    logic [DATA_W-1:0] fifo_head;
    logic              issue;
    logic              key_lock;

    logic wr_mode;
    logic wr_key1;
    logic wr_key2;
    logic wr_key3;
    logic wr_chunk;
    logic wr_clr;
    logic wr_cfg;

    assign wr_mode  = wr_en && (wr_addr == ADDR_MODE);
    assign wr_key1  = wr_en && (wr_addr == ADDR_KEY1);
    assign wr_key2  = wr_en && (wr_addr == ADDR_KEY2);
    assign wr_key3  = wr_en && (wr_addr == ADDR_KEY3);
    assign wr_chunk = wr_en && (wr_addr == ADDR_DATA);
    assign wr_clr   = wr_en && (wr_addr == ADDR_CLR);
    assign wr_cfg   = wr_mode || wr_key1 || wr_key2 || wr_key3;

    assign keys_valid = &key_mask;

    // Chunks queued before the key set is complete cannot have been issued,
    // so the lock only bites once keys are valid; this lets the final key
    // write release chunks that were queued early.
    assign key_lock = (state_q != IDLE) || (!fifo_empty && keys_valid);

    tdes_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (wr_chunk),
        .pop   (issue),
        .flush (wr_clr),
        .data  (wr_data),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A clear leaves the FSM where it is, so it also blocks a pop from IDLE
    // on the same edge.
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        issue      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && keys_valid && !wr_clr) begin
                    issue   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_d    = BUSY;
            end
            BUSY: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            core_data <= '0;
        end else if (issue) begin
            core_data <= fifo_head;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            enc_dec   <= 1'b0;
            key_one   <= '0;
            key_two   <= '0;
            key_three <= '0;
            key_mask  <= '0;
        end else if (!key_lock) begin
            if (wr_mode) begin
                enc_dec <= wr_data[0];
            end
            if (wr_key1) begin
                key_one     <= wr_data;
                key_mask[0] <= 1'b1;
            end
            if (wr_key2) begin
                key_two     <= wr_data;
                key_mask[1] <= 1'b1;
            end
            if (wr_key3) begin
                key_three   <= wr_data;
                key_mask[2] <= 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            overflow_err <= 1'b0;
            key_err      <= 1'b0;
        end else if (wr_clr) begin
            overflow_err <= 1'b0;
            key_err      <= 1'b0;
        end else begin
            if (wr_chunk && fifo_full) begin
                overflow_err <= 1'b1;
            end
            if (wr_cfg && key_lock) begin
                key_err <= 1'b1;
            end
        end
    end

endmodule
